// File: rtl/activity_map_store.sv
// Activity-map storage: WIDTH_P x HEIGHT_P signed saturating counters fed by an event stream,
// with a combinational read port, one-cycle clear and a lock-pausable pixel-serial decay sweep.
module activity_map_store #(
    parameter int unsigned WIDTH_P         = 8,
    parameter int unsigned HEIGHT_P        = 8,
    parameter int unsigned COUNTER_WIDTH_P = 8,
    parameter int unsigned EVCNT_WIDTH_P   = 16,
    localparam int unsigned MAP_SIZE = WIDTH_P * HEIGHT_P,
    localparam int unsigned AW       = $clog2(MAP_SIZE),
    localparam int unsigned XW       = $clog2(WIDTH_P),
    localparam int unsigned YW       = $clog2(HEIGHT_P)
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              event_valid_i,
    output logic                              event_ready_o,
    input  logic [XW-1:0]                     event_x_i,
    input  logic [YW-1:0]                     event_y_i,
    input  logic                              event_pol_i,
    input  logic                              clear_i,
    input  logic                              decay_i,
    input  logic                              lock_i,
    output logic                              busy_o,
    input  logic                              map_read_valid_i,
    input  logic [AW-1:0]                     map_read_addr_i,
    output logic signed [COUNTER_WIDTH_P-1:0] map_read_data_o,
    output logic [EVCNT_WIDTH_P-1:0]          event_count_o
);

    localparam int unsigned C = COUNTER_WIDTH_P;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DECAY = 1'b1;
    localparam logic signed [C-1:0] CNT_MAX = {1'b0, {(C-1){1'b1}}};
    localparam logic signed [C-1:0] CNT_MIN = {1'b1, {(C-1){1'b0}}};

    logic signed [C-1:0]      map_q [MAP_SIZE];
    logic signed [C-1:0]      map_d [MAP_SIZE];
    logic [0:0]               state_q, state_d;
    logic                     pending_q, pending_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic [EVCNT_WIDTH_P-1:0] evcnt_q, evcnt_d;

    logic          ev_fire;
    logic          ev_in_range;
    logic [AW-1:0] ev_addr;
    logic          unused_read_valid;

    function automatic logic signed [C-1:0] sat_step(input logic signed [C-1:0] v,
                                                     input logic up);
        if (up) return (v == CNT_MAX) ? v : v + C'(1);
        return (v == CNT_MIN) ? v : v - C'(1);
    endfunction

    function automatic logic signed [C-1:0] toward_zero(input logic signed [C-1:0] v);
        if (v == '0) return v;
        return v[C-1] ? v + C'(1) : v - C'(1);
    endfunction

    assign unused_read_valid = map_read_valid_i;

    assign event_ready_o = (state_q == S_IDLE) && !lock_i && !clear_i && !pending_q;
    assign ev_fire       = event_valid_i && event_ready_o;
    assign ev_in_range   = (32'(event_x_i) < WIDTH_P) && (32'(event_y_i) < HEIGHT_P);
    assign ev_addr       = AW'(32'(event_y_i) * WIDTH_P + 32'(event_x_i));

    assign busy_o          = pending_q || (state_q == S_DECAY);
    assign event_count_o   = evcnt_q;
    assign map_read_data_o = (32'(map_read_addr_i) < MAP_SIZE) ? map_q[map_read_addr_i] : '0;

    // Events are only accepted in S_IDLE, so event and decay writes never hit the same cycle.
    always_comb begin
        map_d     = map_q;
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        evcnt_d   = evcnt_q;
        if (clear_i) begin
            map_d     = '{default: '0};
            state_d   = S_IDLE;
            pending_d = 1'b0;
            idx_d     = '0;
        end else begin
            if (ev_fire && ev_in_range) begin
                map_d[ev_addr] = sat_step(map_q[ev_addr], event_pol_i);
                evcnt_d        = evcnt_q + EVCNT_WIDTH_P'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (!lock_i && (pending_q || decay_i)) begin
                        state_d   = S_DECAY;
                        idx_d     = '0;
                        pending_d = 1'b0;
                    end else if (lock_i && decay_i) begin
                        pending_d = 1'b1;
                    end
                end
                S_DECAY: begin
                    if (!lock_i) begin
                        map_d[idx_q] = toward_zero(map_q[idx_q]);
                        idx_d        = idx_q + AW'(1);
                        if (32'(idx_q) == MAP_SIZE - 1) state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            map_q     <= '{default: '0};
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            idx_q     <= '0;
            evcnt_q   <= '0;
        end else begin
            map_q     <= map_d;
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            evcnt_q   <= evcnt_d;
        end
    end

endmodule

// File: tb/tb_activity_map_store.sv
// Bench for activity_map_store: vector table, directed corner sequences and random traffic
// checked every cycle against an array-based behavioural model of the 8x8 map.
module tb_activity_map_store;

    logic              clk = 1'b0;
    logic              reset_ni = 1'b1;
    logic              valid = 1'b0;
    logic [2:0]        x = '0;
    logic [2:0]        y = '0;
    logic              pol = 1'b0;
    logic              clear = 1'b0;
    logic              decay = 1'b0;
    logic              lock = 1'b0;
    logic              rvalid = 1'b0;
    logic [5:0]        raddr = '0;

    logic              ready, busy;
    logic signed [7:0] rdata;
    logic [15:0]       count;
    logic              d6_ready, d6_busy;
    logic signed [7:0] d6_data;
    logic [15:0]       d6_count;

    int vectors = 0;
    int miscompares = 0;

    activity_map_store #(.WIDTH_P(8), .HEIGHT_P(8), .COUNTER_WIDTH_P(8), .EVCNT_WIDTH_P(16)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .event_valid_i(valid), .event_ready_o(ready),
        .event_x_i(x), .event_y_i(y), .event_pol_i(pol), .clear_i(clear), .decay_i(decay),
        .lock_i(lock), .busy_o(busy), .map_read_valid_i(rvalid), .map_read_addr_i(raddr),
        .map_read_data_o(rdata), .event_count_o(count)
    );

    // Narrow map (6 columns) sharing all inputs; x=6,7 are out of range here.
    activity_map_store #(.WIDTH_P(6), .HEIGHT_P(8), .COUNTER_WIDTH_P(8), .EVCNT_WIDTH_P(16)) dut6 (
        .clk_i(clk), .reset_ni(reset_ni), .event_valid_i(valid), .event_ready_o(d6_ready),
        .event_x_i(x), .event_y_i(y), .event_pol_i(pol), .clear_i(clear), .decay_i(decay),
        .lock_i(lock), .busy_o(d6_busy), .map_read_valid_i(rvalid), .map_read_addr_i(raddr),
        .map_read_data_o(d6_data), .event_count_o(d6_count)
    );

    always #5 clk = ~clk;

    // Reference model
    int m[64];
    int mcnt;
    bit msweep;
    int mpos;
    bit mpend;

    int last_ready, last_busy, last_data, last_count;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit model_ready();
        return !msweep && !lock && !clear && !mpend;
    endfunction

    task automatic model_reset();
        foreach (m[i]) m[i] = 0;
        mcnt = 0; msweep = 0; mpos = 0; mpend = 0;
    endtask

    task automatic model_edge();
        bit rdy;
        int a;
        rdy = model_ready();
        if (clear) begin
            foreach (m[i]) m[i] = 0;
            msweep = 0; mpend = 0;
        end else begin
            if (valid && rdy && int'(x) < 8 && int'(y) < 8) begin
                a = int'(y) * 8 + int'(x);
                m[a] = m[a] + (pol ? 1 : -1);
                if (m[a] > 127) m[a] = 127;
                if (m[a] < -128) m[a] = -128;
                mcnt = (mcnt + 1) % 65536;
            end
            if (msweep) begin
                if (!lock) begin
                    if (m[mpos] > 0) m[mpos] = m[mpos] - 1;
                    else if (m[mpos] < 0) m[mpos] = m[mpos] + 1;
                    mpos++;
                    if (mpos == 64) msweep = 0;
                end
            end else if (mpend || decay) begin
                if (!lock) begin
                    msweep = 1; mpos = 0; mpend = 0;
                end else begin
                    mpend = 1;
                end
            end
        end
    endtask

    // Inputs are set before calling; outputs are sampled on the falling edge.
    task automatic cycle();
        @(negedge clk);
        last_ready = int'(ready);
        last_busy  = int'(busy);
        last_data  = int'(rdata);
        last_count = int'(count);
        chk("ready", last_ready, int'(model_ready()));
        chk("busy", last_busy, int'(mpend || msweep));
        chk("rdata", last_data, m[raddr]);
        chk("count", last_count, mcnt);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        valid = 0; clear = 0; decay = 0; lock = 0;
        #1;
        model_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_d6_count", int'(d6_count), 0);
        for (int a = 0; a < 64; a++) begin
            raddr = 6'(a);
            #1;
            chk("rst_rdata", int'(rdata), 0);
        end
        @(negedge clk);
        reset_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ev(input bit v, input int ex, input int ey, input bit p);
        valid = v; x = 3'(ex); y = 3'(ey); pol = p;
    endtask

    typedef struct {
        bit valid; int x; int y; bit pol; int raddr; int exp_data; int exp_cnt;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int n;
        tbl[0] = '{1'b1, 2, 1, 1'b1, 10, 0, 0};
        tbl[1] = '{1'b1, 2, 1, 1'b1, 10, 1, 1};
        tbl[2] = '{1'b1, 2, 1, 1'b1, 10, 2, 2};
        tbl[3] = '{1'b0, 2, 1, 1'b1, 10, 3, 3};
        tbl[4] = '{1'b0, 0, 0, 1'b0,  9, 0, 3};
        tbl[5] = '{1'b0, 0, 0, 1'b0, 11, 0, 3};
        tbl[6] = '{1'b0, 0, 0, 1'b0, 63, 0, 3};

        #2;
        do_reset();

        // Basic accumulation
        foreach (tbl[i]) begin
            set_ev(tbl[i].valid, tbl[i].x, tbl[i].y, tbl[i].pol);
            raddr = 6'(tbl[i].raddr);
            cycle();
            chk("tbl_data", last_data, tbl[i].exp_data);
            chk("tbl_count", last_count, tbl[i].exp_cnt);
        end

        // Saturation at both ends
        set_ev(1, 0, 0, 1); raddr = 6'd0;
        repeat (130) cycle();
        set_ev(0, 0, 0, 1);
        cycle();
        chk("sat_hi", last_data, 127);
        set_ev(1, 0, 0, 0);
        repeat (260) cycle();
        set_ev(0, 0, 0, 0);
        cycle();
        chk("sat_lo", last_data, -128);

        // Lock blocks acceptance
        lock = 1; set_ev(1, 3, 3, 1); raddr = 6'd27;
        cycle();
        chk("lock_ready", last_ready, 0);
        lock = 0;
        cycle();
        chk("unlock_ready", last_ready, 1);
        chk("lock_held_data", last_data, 0);
        set_ev(0, 3, 3, 1);
        cycle();
        chk("unlock_evt", last_data, 1);

        // Clear refuses a concurrent event, then build addr5=3, addr6=-2
        clear = 1; set_ev(1, 4, 4, 1);
        cycle();
        chk("clear_ready", last_ready, 0);
        clear = 0;
        set_ev(1, 5, 0, 1); repeat (3) cycle();
        set_ev(1, 6, 0, 0); repeat (2) cycle();
        set_ev(0, 0, 0, 0);
        decay = 1; cycle(); decay = 0;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (last_busy == 0) break;
            n++;
        end
        chk("decay_busy_len", n, 64);
        raddr = 6'd5; cycle(); chk("decay_a5", last_data, 2);
        raddr = 6'd6; cycle(); chk("decay_a6", last_data, -1);
        raddr = 6'd7; cycle(); chk("decay_a7", last_data, 0);

        // Sweep paused by a 10-cycle lock
        decay = 1; cycle(); decay = 0;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            lock = (k >= 30 && k < 40);
            cycle();
            if (last_busy == 0) break;
            n++;
        end
        lock = 0;
        chk("locked_busy_len", n, 74);
        raddr = 6'd5; cycle(); chk("locked_a5", last_data, 1);

        // Clear aborts a sweep
        set_ev(1, 1, 1, 1); repeat (2) cycle();
        set_ev(0, 0, 0, 0); raddr = 6'd9;
        decay = 1; cycle(); decay = 0;
        repeat (20) cycle();
        clear = 1; cycle(); clear = 0;
        cycle();
        chk("clear_busy", last_busy, 0);
        chk("clear_data", last_data, 0);
        decay = 1; lock = 1; cycle(); decay = 0;
        cycle();
        chk("pending_busy", last_busy, 1);
        chk("pending_ready", last_ready, 0);
        lock = 0;
        repeat (70) cycle();

        // Out-of-range column on the 6-wide map
        do_reset();
        set_ev(1, 7, 0, 1);
        #1 chk("d6_oob_ready", int'(d6_ready), 1);
        cycle();
        set_ev(1, 6, 0, 1);
        cycle();
        set_ev(1, 5, 7, 1);
        cycle();
        set_ev(0, 0, 0, 0);
        #1 chk("d6_count", int'(d6_count), 1);
        raddr = 6'd47; #1 chk("d6_rd47", int'(d6_data), 1);
        raddr = 6'd48; #1 chk("d6_rd48", int'(d6_data), 0);
        raddr = 6'd7;  #1 chk("d6_rd7", int'(d6_data), 0);
        raddr = 6'd6;  #1 chk("d6_rd6", int'(d6_data), 0);
        raddr = 6'd61; cycle();
        chk("main_rd61", last_data, 1);

        // Asynchronous reset in the middle of a sweep
        decay = 1; cycle(); decay = 0;
        repeat (10) cycle();
        do_reset();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                x = 3'($urandom_range(0, 1)); y = 3'd0;
            end else begin
                x = 3'($urandom_range(0, 7)); y = 3'($urandom_range(0, 7));
            end
            pol   = 1'($urandom_range(0, 1));
            lock  = ($urandom_range(0, 9) == 0);
            decay = ($urandom_range(0, 49) == 0);
            clear = ($urandom_range(0, 199) == 0);
            rvalid = 1'($urandom_range(0, 1));
            raddr = 6'($urandom_range(0, 63));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
